// File: rtl/ctl_pkg.sv
// ctl_pkg: shared types for the BLI201 multi-cycle sequencer.
//   ctl_state_e : sequencer states (3-bit encoding)
//   ctl_fault_e : halt cause reported on ctl_o_fault
//   WdogWidth   : width of the shared memory-handshake wait counter
package ctl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } ctl_state_e;

  typedef enum logic [1:0] {
    FaultNone    = 2'b00,
    FaultIllegal = 2'b01,
    FaultFetchTo = 2'b10,
    FaultMemTo   = 2'b11
  } ctl_fault_e;

  localparam int unsigned WdogWidth = 8;

endpackage

// File: rtl/ctl_wdog.sv
// ctl_wdog: wait counter for memory handshakes, shared by FETCH and MEM.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count to zero (has priority over en)
//   en         : count one wait cycle
//   expired    : count has reached TIMEOUT (never asserts when TIMEOUT == 0)
module ctl_wdog
  import ctl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WdogWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {WdogWidth{1'b1}})) begin
      // Saturate so a disabled timeout cannot wrap back into a match.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT);

endmodule

// File: rtl/ctl.sv
// ctl: multi-cycle sequencer for the BLI201 core.
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB, drives the
// IR / PC / data-memory / regfile strobes, times out stalled memory handshakes and halts
// on faults (illegal opcode, fetch timeout, memory timeout).
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   ctl_i_ifu_ready          : instruction memory data valid
//   ctl_o_ifu_req, ir_we     : fetch request, instruction register latch (Mealy on ready)
//   ctl_i_is_load/is_store   : decode classification, sampled in DECODE/EXEC
//   ctl_i_illegal            : decode found no opcode group
//   ctl_o_mem_req, mem_we    : data memory request / write
//   ctl_i_mem_ready          : data memory access complete
//   ctl_o_rf_we, pc_we       : one-cycle WB strobes
//   ctl_o_halt, ctl_o_fault  : halted flag and latched cause
//   ctl_o_cycle, instret     : performance counters
// Configuration: define BLI201_CTL_PERF_CNT_EN to build the performance counters;
// otherwise both counter ports read constant 0.
module ctl
  import ctl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctl_i_ifu_ready,
  output logic        ctl_o_ifu_req,
  output logic        ctl_o_ir_we,
  input  logic        ctl_i_is_load,
  input  logic        ctl_i_is_store,
  input  logic        ctl_i_illegal,
  output logic        ctl_o_mem_req,
  output logic        ctl_o_mem_we,
  input  logic        ctl_i_mem_ready,
  output logic        ctl_o_rf_we,
  output logic        ctl_o_pc_we,
  output logic        ctl_o_halt,
  output logic [1:0]  ctl_o_fault,
  output logic [31:0] ctl_o_cycle,
  output logic [31:0] ctl_o_instret
);

  ctl_state_e state_q, state_d;
  ctl_fault_e fault_q, fault_d;
  logic       is_store_q, is_store_d;
  logic       wdog_clr, wdog_en, wdog_expired;

  // Counter is held clear outside the two waiting states, so it starts at zero on entry.
  assign wdog_clr = !((state_q == StFetch) || (state_q == StMem));
  assign wdog_en  = ((state_q == StFetch) && !ctl_i_ifu_ready) ||
                    ((state_q == StMem) && !ctl_i_mem_ready);

  ctl_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    is_store_d = is_store_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        // A ready on the expiry cycle still wins over the timeout.
        if (ctl_i_ifu_ready) begin
          state_d = StDecode;
        end else if (wdog_expired) begin
          state_d = StHalt;
          fault_d = FaultFetchTo;
        end
      end
      StDecode: begin
        if (ctl_i_illegal) begin
          state_d = StHalt;
          fault_d = FaultIllegal;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        is_store_d = ctl_i_is_store;
        state_d    = (ctl_i_is_load || ctl_i_is_store) ? StMem : StWb;
      end
      StMem: begin
        if (ctl_i_mem_ready) begin
          state_d = StWb;
        end else if (wdog_expired) begin
          state_d = StHalt;
          fault_d = FaultMemTo;
        end
      end
      StWb:   state_d = StFetch;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fault_q    <= FaultNone;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      is_store_q <= is_store_d;
    end
  end

  // Outputs decode straight from the state register so reset removes them immediately.
  always_comb begin
    ctl_o_ifu_req = (state_q == StFetch);
    ctl_o_ir_we   = (state_q == StFetch) && ctl_i_ifu_ready;
    ctl_o_mem_req = (state_q == StMem);
    ctl_o_mem_we  = (state_q == StMem) && is_store_q;
    ctl_o_rf_we   = (state_q == StWb);
    ctl_o_pc_we   = (state_q == StWb);
    ctl_o_halt    = (state_q == StHalt);
    ctl_o_fault   = fault_q;
  end

`ifdef BLI201_CTL_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if ((state_q != StIdle) && (state_q != StHalt)) begin
        cycle_q <= cycle_q + 32'd1;
      end
      if (state_q == StWb) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign ctl_o_cycle   = cycle_q;
  assign ctl_o_instret = instret_q;
`else
  assign ctl_o_cycle   = '0;
  assign ctl_o_instret = '0;
`endif

endmodule

// File: tb/tb_ctl.sv
// tb_ctl: self-checking bench for ctl. Each cycle is a record of driven inputs and
// expected outputs; records come from a hand table and from an instruction-level
// generator (class, fetch waits, memory waits) that expands each instruction into
// its expected per-cycle trace.
module tb_ctl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_ready, is_load, is_store, illegal, mem_ready;
  logic        ifu_req, ir_we, mem_req, mem_we, rf_we, pc_we, halt;
  logic [1:0]  fault;
  logic [31:0] cycle, instret;

  always #5 clk = ~clk;

  ctl #(
    .TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctl_i_ifu_ready (ifu_ready),
    .ctl_o_ifu_req   (ifu_req),
    .ctl_o_ir_we     (ir_we),
    .ctl_i_is_load   (is_load),
    .ctl_i_is_store  (is_store),
    .ctl_i_illegal   (illegal),
    .ctl_o_mem_req   (mem_req),
    .ctl_o_mem_we    (mem_we),
    .ctl_i_mem_ready (mem_ready),
    .ctl_o_rf_we     (rf_we),
    .ctl_o_pc_we     (pc_we),
    .ctl_o_halt      (halt),
    .ctl_o_fault     (fault),
    .ctl_o_cycle     (cycle),
    .ctl_o_instret   (instret)
  );

  typedef struct packed {
    logic       ifu_ready;
    logic       is_load;
    logic       is_store;
    logic       illegal;
    logic       mem_ready;
    logic [6:0] outs;   // {ifu_req, ir_we, mem_req, mem_we, rf_we, pc_we, halt}
    logic [1:0] fault;
    logic       busy;   // cycle counts toward the cycle counter
  } vec_t;

  vec_t        q[$];
  vec_t        tbl[11];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned exp_cyc, exp_ins;

  function automatic vec_t mk(logic fr, logic ld, logic st, logic il, logic mr,
                              logic [6:0] o, logic [1:0] f, logic b);
    vec_t v;
    v.ifu_ready = fr;
    v.is_load   = ld;
    v.is_store  = st;
    v.illegal   = il;
    v.mem_ready = mr;
    v.outs      = o;
    v.fault     = f;
    v.busy      = b;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(int unsigned v);
`ifdef BLI201_CTL_PERF_CNT_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic push_idle();
    q.push_back(mk(rb(), rb(), rb(), rb(), rb(), 7'b0, 2'b00, 1'b0));
  endtask

  task automatic push_halt(logic [1:0] f, int n);
    for (int i = 0; i < n; i++) q.push_back(mk(rb(), rb(), rb(), rb(), rb(), 7'b0000001, f, 1'b0));
  endtask

  // cls: 0 alu/branch/jump, 1 load, 2 store, 3 illegal. wf/wm: cycles ready stays low.
  task automatic gen_instr(int cls, int wf, int wm, int nh, output bit halted);
    logic ld, st, il;
    ld = (cls == 1);
    st = (cls == 2);
    il = (cls == 3);
    halted = 1'b1;
    for (int i = 0; ; i++) begin
      if (i < wf) begin
        q.push_back(mk(1'b0, rb(), rb(), rb(), rb(), 7'b1000000, 2'b00, 1'b1));
        if (TO != 0 && i == int'(TO)) begin
          push_halt(2'b10, nh);
          return;
        end
      end else begin
        q.push_back(mk(1'b1, rb(), rb(), rb(), rb(), 7'b1100000, 2'b00, 1'b1));
        break;
      end
    end
    q.push_back(mk(rb(), ld, st, il, rb(), 7'b0, 2'b00, 1'b1));
    if (il) begin
      push_halt(2'b01, nh);
      return;
    end
    q.push_back(mk(rb(), ld, st, 1'b0, rb(), 7'b0, 2'b00, 1'b1));
    if (ld || st) begin
      for (int i = 0; ; i++) begin
        if (i < wm) begin
          q.push_back(mk(rb(), ld, st, 1'b0, 1'b0, {2'b00, 1'b1, st, 3'b000}, 2'b00, 1'b1));
          if (TO != 0 && i == int'(TO)) begin
            push_halt(2'b11, nh);
            return;
          end
        end else begin
          q.push_back(mk(rb(), ld, st, 1'b0, 1'b1, {2'b00, 1'b1, st, 3'b000}, 2'b00, 1'b1));
          break;
        end
      end
    end
    q.push_back(mk(rb(), ld, st, 1'b0, rb(), 7'b0000110, 2'b00, 1'b1));
    halted = 1'b0;
  endtask

  // Leaves the bench 1 time unit after the edge that starts the IDLE cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    {ifu_ready, is_load, is_store, illegal, mem_ready} = '0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'({ifu_req, ir_we, mem_req, mem_we, rf_we, pc_we, halt, fault}), 32'd0);
    check("reset_cycle", cycle, 32'd0);
    check("reset_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cyc = 0;
    exp_ins = 0;
  endtask

  task automatic run_q(int nmax);
    vec_t v;
    for (int k = 0; k < q.size() && k < nmax; k++) begin
      v = q[k];
      ifu_ready = v.ifu_ready;
      is_load   = v.is_load;
      is_store  = v.is_store;
      illegal   = v.illegal;
      mem_ready = v.mem_ready;
      @(negedge clk);
      check($sformatf("outs[%0d]", k),
            32'({ifu_req, ir_we, mem_req, mem_we, rf_we, pc_we, halt, fault}),
            32'({v.outs, v.fault}));
      check($sformatf("cycle[%0d]", k), cycle, cnt_exp(exp_cyc));
      check($sformatf("instret[%0d]", k), instret, cnt_exp(exp_ins));
      if (v.busy) exp_cyc++;
      if (v.outs[2]) exp_ins++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit h;
    int n, r;

    // ALU then load; ready inputs held high where they must be ignored.
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100000, 2'b00, 1'b1);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 1'b1);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 1'b1);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000110, 2'b00, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 2'b00, 1'b1);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100000, 2'b00, 1'b1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b00, 1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 1'b1);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0010000, 2'b00, 1'b1);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000110, 2'b00, 1'b1);

    do_reset();
    foreach (tbl[i]) q.push_back(tbl[i]);
    run_q(q.size());

    // Load with three wait cycles, then store with zero waits.
    do_reset();
    push_idle();
    gen_instr(1, 0, 3, 3, h);
    gen_instr(2, 0, 0, 3, h);
    gen_instr(0, 1, 0, 3, h);
    run_q(q.size());

    // Illegal opcode: halt with fault 01 held for 100 cycles.
    do_reset();
    push_idle();
    gen_instr(0, 0, 0, 3, h);
    gen_instr(3, 0, 0, 100, h);
    run_q(q.size());

    // Fetch timeout with ready held low.
    do_reset();
    push_idle();
    gen_instr(0, 50, 0, 5, h);
    run_q(q.size());

    // Ready on the expiry cycle wins, then a memory timeout.
    do_reset();
    push_idle();
    gen_instr(0, int'(TO), 0, 3, h);
    gen_instr(2, 0, int'(TO), 3, h);
    gen_instr(1, 0, 20, 5, h);
    run_q(q.size());

    // Reset asserted in the middle of a memory wait.
    do_reset();
    push_idle();
    gen_instr(1, 0, 3, 3, h);
    run_q(5);
    mem_ready = 1'b0;
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_mem_req", 32'(mem_req), 32'd0);
    check("async_halt_fault", 32'({halt, fault}), 32'd0);
    check("async_cycle", cycle, 32'd0);
    check("async_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cyc = 0;
    exp_ins = 0;
    q.delete();
    push_idle();
    gen_instr(0, 0, 0, 3, h);
    run_q(q.size());

    // Random instruction streams.
    repeat (40) begin
      do_reset();
      push_idle();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 19);
        gen_instr((r == 0) ? 3 : (r % 3), $urandom_range(0, 5), $urandom_range(0, 5), 3, h);
        if (h) break;
      end
      run_q(q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
